// File: rtl/controle_ldst_pkg.sv
// Shared encodings for the load/store controller:
// FSM states, op codes and adder mode codes.
package controle_ldst_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CALC    = 3'd1,
    ESCRITA = 3'd2,
    LEITURA = 3'd3,
    CARGA   = 3'd4,
    FIM     = 3'd5
  } state_t;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  localparam logic SOMA    = 1'b0;
  localparam logic SUBTRAI = 1'b1;

endpackage

// File: rtl/controle_ldst.sv
// Load/store controller: computes an address through an external
// adder, then moves a word between register file and memory.
module controle_ldst
  import controle_ldst_pkg::*;
#(
  parameter int LAT_MEM = 1,
  parameter int AW      = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op,
  input  logic          sub,
  input  logic [4:0]    a_in,
  input  logic [4:0]    b_in,
  input  logic [4:0]    reg_idx,
  output logic          busy,
  output logic          done,
  output logic          erro,
  output logic [4:0]    a,
  output logic [4:0]    b,
  output logic          sinal,
  input  logic [AW-1:0] soma,
  output logic [AW-1:0] ads,
  output logic          we_mem,
  output logic [4:0]    Ra,
  output logic [4:0]    Rw,
  output logic          we_reg
);

  localparam logic [2:0] LAST = 3'(LAT_MEM - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_op;
  logic          r_sub;
  logic          r_uf;
  logic [4:0]    r_a;
  logic [4:0]    r_b;
  logic [4:0]    r_idx;
  logic [AW-1:0] r_ads;
  logic [2:0]    r_cnt;
  logic          w_uf;

  assign w_uf = (r_sub == SUBTRAI) && (r_a < r_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= OP_LOAD;
      r_sub   <= SOMA;
      r_uf    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_ads   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_op  <= op;
        r_sub <= sub;
        r_a   <= a_in;
        r_b   <= b_in;
        r_idx <= reg_idx;
      end
      if (r_state == CALC) begin
        r_ads <= soma;
        r_uf  <= w_uf;
      end
      if (r_state == LEITURA) r_cnt <= r_cnt + 3'd1;
      else                    r_cnt <= '0;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    erro   = 1'b0;
    we_mem = 1'b0;
    we_reg = 1'b0;
    a      = '0;
    b      = '0;
    sinal  = SOMA;
    Ra     = '0;
    Rw     = '0;
    if (r_state != IDLE) begin
      busy  = 1'b1;
      a     = r_a;
      b     = r_b;
      sinal = r_sub;
      Ra    = r_idx;
      Rw    = r_idx;
    end
    unique case (r_state)
      IDLE:    if (start) w_next = CALC;
      CALC: begin
        if (w_uf)                 w_next = FIM;
        else if (r_op == OP_STORE) w_next = ESCRITA;
        else                      w_next = LEITURA;
      end
      ESCRITA: begin
        we_mem = 1'b1;
        w_next = FIM;
      end
      LEITURA: if (r_cnt == LAST) w_next = CARGA;
      CARGA: begin
        we_reg = 1'b1;
        w_next = FIM;
      end
      FIM: begin
        done   = 1'b1;
        erro   = r_uf;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // a reset edge must not commit a pending write
    if (rst) begin
      we_mem = 1'b0;
      we_reg = 1'b0;
    end
  end

  assign ads = r_ads;

endmodule

// File: tb/tb_controle_ldst.sv
// Directed bench: controller with behavioural adder, register
// file and memory wired beside it.
module tb_controle_ldst;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic       sub = 1'b0;
  logic [4:0] a_in = '0;
  logic [4:0] b_in = '0;
  logic [4:0] reg_idx = '0;
  logic       busy, done, erro, sinal, we_mem, we_reg;
  logic [4:0] a, b, Ra, Rw;
  logic [5:0] soma, ads;

  logic [7:0] mem [64];
  logic [7:0] rf  [32];
  logic [7:0] mdout;
  logic       clr = 1'b1;
  logic       pre_we = 1'b0;
  logic [4:0] pre_idx = '0;
  logic [7:0] pre_dat = '0;

  int errs = 0;
  int checks = 0;
  int ndone, dcyc, nwm, nwr, wads, wrw, derr, both;
  int busy_after, a2, b2, ra1;

  controle_ldst #(.LAT_MEM(1), .AW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .sub(sub),
    .a_in(a_in), .b_in(b_in), .reg_idx(reg_idx),
    .busy(busy), .done(done), .erro(erro),
    .a(a), .b(b), .sinal(sinal), .soma(soma), .ads(ads),
    .we_mem(we_mem), .Ra(Ra), .Rw(Rw), .we_reg(we_reg)
  );

  always #5 clk = ~clk;

  assign soma = sinal ? (6'(a) - 6'(b)) : (6'(a) + 6'(b));

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (we_mem) mem[ads] <= rf[Ra];
      if (we_reg) rf[Rw] <= mdout;
      if (pre_we) rf[pre_idx] <= pre_dat;
    end
    mdout <= mem[ads];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic go(input logic o, input logic s,
                    input logic [4:0] x, input logic [4:0] y,
                    input logic [4:0] idx, input int pulse,
                    input int rcyc);
    @(negedge clk);
    op = o; sub = s; a_in = x; b_in = y; reg_idx = idx;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = ~o; sub = ~s; a_in = ~x; b_in = ~y; reg_idx = ~idx;
    ndone = 0; dcyc = 0; nwm = 0; nwr = 0; wads = -1; wrw = -1;
    derr = 0; both = 0; busy_after = -1; a2 = -1; b2 = -1; ra1 = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (we_mem) begin nwm++; wads = int'(ads); end
      if (we_reg) begin nwr++; wrw = int'(Rw); end
      if (we_mem && we_reg) both++;
      if (done) begin ndone++; dcyc = c; derr = int'(erro); end
      if (c == 1) ra1 = int'(Ra);
      if (c == 2) begin a2 = int'(a); b2 = int'(b); end
      if (c == rcyc) rst = 1'b1;
      if (c == rcyc + 1) begin busy_after = int'(busy); rst = 1'b0; end
      start = (pulse != 0 && c <= 3);
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", {done, erro}, 0);
    chk("rst_we", {we_mem, we_reg}, 0);
    chk("rst_ads", ads, 0);
    chk("rst_ops", {a, b, sinal, Ra, Rw}, 0);
    start = 1'b1; op = 1'b1; a_in = 5'd4;
    @(negedge clk);
    clr = 1'b0; rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("start_in_rst", busy, 0);

    pre_we = 1'b1; pre_idx = 5'd0; pre_dat = 8'd32;
    @(negedge clk);
    pre_we = 1'b0;

    go(1'b1, 1'b0, 5'd0, 5'd7, 5'd0, 1, 0);
    chk("st_done_cyc", dcyc, 3);
    chk("st_ndone", ndone, 1);
    chk("st_nwm", nwm, 1);
    chk("st_ads", wads, 7);
    chk("st_nwr", nwr, 0);
    chk("st_erro", derr, 0);
    chk("st_mem7", mem[7], 32);
    chk("st_a_hold", a2, 0);
    chk("st_b_hold", b2, 7);
    chk("st_ra_calc", ra1, 0);
    chk("st_both", both, 0);

    go(1'b0, 1'b0, 5'd0, 5'd7, 5'd12, 0, 0);
    chk("ld_done_cyc", dcyc, 4);
    chk("ld_nwr", nwr, 1);
    chk("ld_rw", wrw, 12);
    chk("ld_nwm", nwm, 0);
    chk("ld_rf12", rf[12], 32);
    chk("ld_ra_calc", ra1, 12);

    go(1'b1, 1'b1, 5'd3, 5'd5, 5'd0, 0, 0);
    chk("uf_done_cyc", dcyc, 2);
    chk("uf_erro", derr, 1);
    chk("uf_nwm", nwm, 0);
    chk("uf_nwr", nwr, 0);

    go(1'b1, 1'b1, 5'd9, 5'd9, 5'd12, 0, 0);
    chk("eq_ads", wads, 0);
    chk("eq_erro", derr, 0);
    chk("eq_done_cyc", dcyc, 3);
    chk("eq_mem0", mem[0], 32);

    go(1'b1, 1'b0, 5'd31, 5'd31, 5'd0, 0, 0);
    chk("max_ads", wads, 62);
    chk("max_mem62", mem[62], 32);

    go(1'b1, 1'b0, 5'd20, 5'd0, 5'd0, 0, 2);
    chk("rw_busy", busy_after, 0);
    chk("rw_ndone", ndone, 0);
    chk("rw_mem20", mem[20], 0);
    go(1'b1, 1'b0, 5'd20, 5'd0, 5'd0, 0, 0);
    chk("rw_again_cyc", dcyc, 3);
    chk("rw_again_mem", mem[20], 32);

    go(1'b0, 1'b0, 5'd7, 5'd0, 5'd5, 0, 2);
    chk("rl_busy", busy_after, 0);
    chk("rl_ndone", ndone, 0);
    chk("rl_rf5", rf[5], 0);
    go(1'b0, 1'b0, 5'd7, 5'd0, 5'd5, 0, 0);
    chk("rl_again_cyc", dcyc, 4);
    chk("rl_again_rf", rf[5], 32);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
